morse_encoder: RTL and testbench
================================

# morse_encoder

Character-to-Morse keyer for the Morse path: accepts one ASCII character per valid/ready handshake and drives a single timed key line. The line carries dots, dashes and standard gaps with unit-based timing. Default timing places a dot inside the 100–1999-cycle press window and a dash at or above 2000 cycles, so a button-style Morse receiver in the design classifies the output correctly. Sits between a character source (host, FIFO, test stimulus) and the key/LED output pin.

## Interface
- UNIT_CYCLES, 800, length of one Morse time unit in clk cycles; legal range 1 or more.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- char_in  input  8  ASCII code, sampled on handshake.
- char_valid  input  1  char_in holds a character to send.
- char_ready  output  1  encoder can accept; equals (state == IDLE) && !rst.
- key_out  output  1  Morse key line, 1 = mark (key down); registered.
- err  output  1  one-cycle pulse indicating an unsupported code was accepted and dropped; registered.

## Operation
- Handshake: accept when char_valid && char_ready at a rising edge; char_in is captured into a pattern register at that edge. char_valid is ignored outside IDLE.
- Supported codes:
  - 'A'–'Z' (0x41–0x5A) use the ITU pattern.
  - 'a'–'z' (0x61–0x7A) map to uppercase.
  - '0'–'9' (0x30–0x39) use the ITU 5-element pattern.
  - ' ' (0x20) is a word gap.
- Pattern storage: 5-bit pattern, MSB-first, 1 = dash. A 3-bit length field (1–5) gives the element count.
- Unsupported code: nothing is keyed, err = 1 for exactly one cycle, and the state stays IDLE.
- State machine:
  - IDLE: key low, ready.
    - Supported non-space character: go to MARK.
    - Space: go to WORD_GAP.
    - Unsupported code: stay in IDLE and pulse err.
  - MARK: key high for UNIT_CYCLES (dot) or 3·UNIT_CYCLES (dash).
    - More elements remain: go to ELEM_GAP.
    - Last element: go to CHAR_GAP.
  - ELEM_GAP: key low for UNIT_CYCLES, then MARK with the next element.
  - CHAR_GAP: key low for 3·UNIT_CYCLES, then IDLE.
  - WORD_GAP: key low for 7·UNIT_CYCLES, then IDLE.
- Duration counter:
  - Width is $clog2(7·UNIT_CYCLES+1).
  - Loads the target duration minus 1 on each state entry and counts down.
  - The state advances at the edge where the counter reads 0.
  - The counter never wraps.
- Element index: counts up from 0 to length−1 and selects the pattern bit.
- Reset (any cycle, including mid-character): at the next edge the state goes to IDLE and key_out, err, counter, index and pattern all go to 0. No partial gap is emitted. char_ready reads 0 while rst is high and 1 on the first cycle after release.

## Timing
- Reset values: key_out = 0, err = 0. char_ready = 0 during rst, 1 afterwards.
- Let t = the accepting edge.
  - key_out first rises for cycle t+1 (one cycle of latency).
  - The first mark occupies cycles t+1 … t+D, where D = U or 3U and U = UNIT_CYCLES.
- Every mark is exactly 1U or 3U cycles; every gap is exactly 1U, 3U or 7U cycles. There are no extra bubbles between states.
- char_ready returns 1 on the first cycle after the final CHAR_GAP or WORD_GAP cycle. A character presented then is accepted on that edge, so held-valid back-to-back characters are separated by exactly 3U.
- err is asserted in cycle t+1 only, and char_ready is 1 in that same cycle.
- An invalid character therefore costs one cycle. A new character may be accepted at edge t+1.

## Test plan
- Reset: hold rst for 3 cycles while char_valid = 1 with 'E' → key_out = 0, err = 0, char_ready = 0 throughout, nothing accepted. After release char_ready = 1.
- 'E' (0x45), UNIT_CYCLES = 4: accept at t → key_out = 1 for cycles t+1..t+4 and 0 for t+5..t+16. char_ready = 0 over t+1..t+16 and 1 at t+17.
- 'a' (0x61), U = 4 → key pattern 4 high, 4 low, 12 high, 12 low. char_ready is 1 again 33 cycles after accept, identical to 'A'. Then '0' → five 12-cycle marks separated by 4-cycle gaps, followed by a 12-cycle low.
- Space and invalid, U = 4:
  - 0x20 → key_out = 0 for 28 cycles, char_ready at t+29.
  - '#' (0x23) → err = 1 in cycle t+1 only, no key activity, char_ready = 1 at t+1.
  - 'T' presented at t+1 is accepted there.
- Back-to-back: char_valid held high with 'S' then 'T', U = 4 → S = three 4-cycle marks with 4-cycle gaps, then exactly 12 low cycles, then a 12-cycle T mark. No bubble is allowed.
- Reset mid-operation: send 'O', U = 4, and assert rst for 1 cycle during the second dash → key_out = 0 the cycle after the reset edge and char_ready = 1 the cycle after release. A following 'E' keys correctly with no residual elements.

Source files
------------

// File: rtl/morse_encoder.sv
// rtl/morse_encoder.sv - ASCII character to timed Morse key line encoder
// One character per valid/ready handshake; dots, dashes and gaps timed in UNIT_CYCLES.
module morse_encoder #(
  parameter int UNIT_CYCLES = 800
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       err
);

  localparam int CW = $clog2(7 * UNIT_CYCLES + 1);
  localparam logic [CW-1:0] DOT_M1  = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] DASH_M1 = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] WORD_M1 = CW'(7 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, MARK, ELEM_GAP, CHAR_GAP, WORD_GAP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, dur;
  logic [2:0]      idx, len;
  logic [4:0]      pattern;
  logic [7:0]      upper;
  logic [2:0]      lut_len;
  logic [4:0]      lut_pat;
  logic            lut_ok, is_space, accept, last_elem, elem_bit, cnt_done;

  assign char_ready = (state == IDLE) && !rst;
  assign accept     = char_valid && char_ready;
  assign is_space   = (char_in == 8'h20);
  assign lut_ok     = (lut_len != 3'd0);
  assign cnt_done   = (cnt == '0);
  assign last_elem  = (idx == len - 3'd1);

  // Patterns are left-aligned: bit 4 is the first element, 1 = dash.
  always_comb begin
    lut_len = 3'd0;
    lut_pat = 5'b00000;
    upper   = (char_in >= 8'h61 && char_in <= 8'h7A) ? char_in - 8'h20 : char_in;
    case (upper)
      8'h41: {lut_len, lut_pat} = {3'd2, 5'b01000};
      8'h42: {lut_len, lut_pat} = {3'd4, 5'b10000};
      8'h43: {lut_len, lut_pat} = {3'd4, 5'b10100};
      8'h44: {lut_len, lut_pat} = {3'd3, 5'b10000};
      8'h45: {lut_len, lut_pat} = {3'd1, 5'b00000};
      8'h46: {lut_len, lut_pat} = {3'd4, 5'b00100};
      8'h47: {lut_len, lut_pat} = {3'd3, 5'b11000};
      8'h48: {lut_len, lut_pat} = {3'd4, 5'b00000};
      8'h49: {lut_len, lut_pat} = {3'd2, 5'b00000};
      8'h4A: {lut_len, lut_pat} = {3'd4, 5'b01110};
      8'h4B: {lut_len, lut_pat} = {3'd3, 5'b10100};
      8'h4C: {lut_len, lut_pat} = {3'd4, 5'b01000};
      8'h4D: {lut_len, lut_pat} = {3'd2, 5'b11000};
      8'h4E: {lut_len, lut_pat} = {3'd2, 5'b10000};
      8'h4F: {lut_len, lut_pat} = {3'd3, 5'b11100};
      8'h50: {lut_len, lut_pat} = {3'd4, 5'b01100};
      8'h51: {lut_len, lut_pat} = {3'd4, 5'b11010};
      8'h52: {lut_len, lut_pat} = {3'd3, 5'b01000};
      8'h53: {lut_len, lut_pat} = {3'd3, 5'b00000};
      8'h54: {lut_len, lut_pat} = {3'd1, 5'b10000};
      8'h55: {lut_len, lut_pat} = {3'd3, 5'b00100};
      8'h56: {lut_len, lut_pat} = {3'd4, 5'b00010};
      8'h57: {lut_len, lut_pat} = {3'd3, 5'b01100};
      8'h58: {lut_len, lut_pat} = {3'd4, 5'b10010};
      8'h59: {lut_len, lut_pat} = {3'd4, 5'b10110};
      8'h5A: {lut_len, lut_pat} = {3'd4, 5'b11000};
      8'h30: {lut_len, lut_pat} = {3'd5, 5'b11111};
      8'h31: {lut_len, lut_pat} = {3'd5, 5'b01111};
      8'h32: {lut_len, lut_pat} = {3'd5, 5'b00111};
      8'h33: {lut_len, lut_pat} = {3'd5, 5'b00011};
      8'h34: {lut_len, lut_pat} = {3'd5, 5'b00001};
      8'h35: {lut_len, lut_pat} = {3'd5, 5'b00000};
      8'h36: {lut_len, lut_pat} = {3'd5, 5'b10000};
      8'h37: {lut_len, lut_pat} = {3'd5, 5'b11000};
      8'h38: {lut_len, lut_pat} = {3'd5, 5'b11100};
      8'h39: {lut_len, lut_pat} = {3'd5, 5'b11110};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && is_space)    state_next = WORD_GAP;
        else if (accept && lut_ok) state_next = MARK;
      end
      MARK:     if (cnt_done) state_next = last_elem ? CHAR_GAP : ELEM_GAP;
      ELEM_GAP: if (cnt_done) state_next = MARK;
      CHAR_GAP: if (cnt_done) state_next = IDLE;
      WORD_GAP: if (cnt_done) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // On entry to MARK from IDLE the pattern is not yet registered, so use the lookup.
  always_comb begin
    elem_bit = (state == IDLE) ? lut_pat[4] : pattern[3'd4 - idx];
    case (state_next)
      MARK:     dur = elem_bit ? DASH_M1 : DOT_M1;
      ELEM_GAP: dur = DOT_M1;
      CHAR_GAP: dur = DASH_M1;
      WORD_GAP: dur = WORD_M1;
      default:  dur = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_out <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
      idx     <= 3'd0;
      len     <= 3'd0;
      pattern <= 5'b00000;
    end else begin
      key_out <= (state_next == MARK);
      err     <= accept && !is_space && !lut_ok;
      if (state_next != state) cnt <= dur;
      else if (!cnt_done)      cnt <= cnt - 1'b1;
      if (state == IDLE && accept && lut_ok) begin
        pattern <= lut_pat;
        len     <= lut_len;
        idx     <= 3'd0;
      end else if (state == MARK && cnt_done && !last_elem) begin
        idx <= idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// tb/tb_morse_encoder.sv - directed self-checking bench for morse_encoder
// UNIT_CYCLES = 4: dot 4, dash 12, element gap 4, character gap 12, word gap 28.
module tb_morse_encoder;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready, key_out, err;
  int         errors = 0;
  int         checks = 0;

  morse_encoder #(.UNIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .key_out(key_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; character is accepted at the following posedge.
  task automatic send(input logic [7:0] c);
    char_in    = c;
    char_valid = 1'b1;
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  // n cycles of key_out == v with char_ready low throughout.
  task automatic run(input string tag, input logic v, input int n);
    int hits = 0;
    int busy = 0;
    repeat (n) begin
      @(negedge clk);
      if (key_out === v) hits++;
      if (char_ready === 1'b0 && err === 1'b0) busy++;
    end
    check({tag, "_key"}, hits, n);
    check({tag, "_busy"}, busy, n);
  endtask

  task automatic ready_now(input string tag);
    @(negedge clk);
    check(tag, {30'd0, char_ready, key_out}, 2);
  endtask

  task automatic measure(input logic [7:0] c, input int exp_busy, input int exp_mark);
    int busy = 0;
    int marks = 0;
    send(c);
    @(negedge clk);
    while (!char_ready && busy < 300) begin
      busy++;
      if (key_out) marks++;
      @(negedge clk);
    end
    check($sformatf("busy_%c", c), busy, exp_busy);
    check($sformatf("marks_%c", c), marks, exp_mark);
  endtask

  initial begin
    rst = 1'b1;
    char_valid = 1'b1;
    char_in = 8'h45;
    begin
      int bad = 0;
      repeat (3) begin
        @(negedge clk);
        if (key_out !== 1'b0 || err !== 1'b0 || char_ready !== 1'b0) bad++;
      end
      check("reset_outputs", bad, 0);
    end
    rst = 1'b0;
    char_valid = 1'b0;
    #1 check("ready_after_reset", char_ready, 1);
    check("key_after_reset", key_out, 0);

    // 'E'
    send(8'h45);
    run("E_mark", 1'b1, 4);
    run("E_cgap", 1'b0, 12);
    ready_now("E_ready_t17");

    // 'a' then '0'
    send(8'h61);
    run("a_dot", 1'b1, 4);
    run("a_egap", 1'b0, 4);
    run("a_dash", 1'b1, 12);
    run("a_cgap", 1'b0, 12);
    ready_now("a_ready_t33");
    send(8'h30);
    for (int i = 0; i < 5; i++) begin
      run($sformatf("zero_dash%0d", i), 1'b1, 12);
      if (i < 4) run($sformatf("zero_egap%0d", i), 1'b0, 4);
    end
    run("zero_cgap", 1'b0, 12);
    ready_now("zero_ready");

    // space, invalid, then 'T' on the very next edge
    send(8'h20);
    run("space_gap", 1'b0, 28);
    ready_now("space_ready_t29");
    send(8'h23);
    @(negedge clk);
    check("inv_err_ready_key", {29'd0, err, char_ready, key_out}, 6);
    send(8'h54);
    @(negedge clk);
    check("inv_err_cleared", err, 0);
    check("T_first_mark", key_out, 1);
    run("T_mark_rest", 1'b1, 11);
    run("T_cgap", 1'b0, 12);
    ready_now("T_ready");

    // held valid: 'S' then 'T'
    char_in = 8'h53;
    char_valid = 1'b1;
    @(posedge clk);
    #1 char_in = 8'h54;
    run("S_dot0", 1'b1, 4);
    run("S_egap0", 1'b0, 4);
    run("S_dot1", 1'b1, 4);
    run("S_egap1", 1'b0, 4);
    run("S_dot2", 1'b1, 4);
    run("S_cgap", 1'b0, 12);
    ready_now("btb_accept_cycle");
    @(posedge clk);
    #1 char_valid = 1'b0;
    run("btb_T_mark", 1'b1, 12);
    run("btb_T_cgap", 1'b0, 12);
    ready_now("btb_ready");

    // reset during the second dash of 'O'
    send(8'h4F);
    run("O_dash0", 1'b1, 12);
    run("O_egap0", 1'b0, 4);
    run("O_dash1_part", 1'b1, 5);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_key_err_ready", {29'd0, key_out, err, char_ready}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_key", {30'd0, char_ready, key_out}, 2);
    send(8'h45);
    run("post_rst_E_mark", 1'b1, 4);
    run("post_rst_E_cgap", 1'b0, 12);
    ready_now("post_rst_ready");

    // pattern table spot checks: busy cycles and total mark cycles
    measure(8'h42, 48, 24);
    measure(8'h7A, 56, 32);
    measure(8'h39, 80, 52);
    measure(8'h4B, 48, 28);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
